seg7_scan: RTL and testbench

//   Output-side display driver for the Basys3 board: takes a 16-bit value (e.g. ALU

---
 rtl/seg7_scan.sv | 130 +++++++++++++
 tb/tb_seg7_scan.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex driver for a common-anode 7-segment display.
// Inputs are captured once per frame so a digit scan never mixes two values.
module seg7_scan #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] value_i,
  input  logic [3:0]  blank_i,
  input  logic [3:0]  dp_i,
  input  logic        lz_en_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hexSeg(input logic [3:0] nib);
    case (nib)
      4'h0:    hexSeg = 7'b1000000;
      4'h1:    hexSeg = 7'b1111001;
      4'h2:    hexSeg = 7'b0100100;
      4'h3:    hexSeg = 7'b0110000;
      4'h4:    hexSeg = 7'b0011001;
      4'h5:    hexSeg = 7'b0010010;
      4'h6:    hexSeg = 7'b0000010;
      4'h7:    hexSeg = 7'b1111000;
      4'h8:    hexSeg = 7'b0000000;
      4'h9:    hexSeg = 7'b0010000;
      4'hA:    hexSeg = 7'b0001000;
      4'hB:    hexSeg = 7'b0000011;
      4'hC:    hexSeg = 7'b1000110;
      4'hD:    hexSeg = 7'b0100001;
      4'hE:    hexSeg = 7'b0000110;
      4'hF:    hexSeg = 7'b0001110;
      default: hexSeg = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0] cntR;
  logic [1:0]    idxR;
  logic [15:0]   valueR;
  logic [3:0]    blankR;
  logic [3:0]    dpMaskR;
  logic          lzEnR;

  logic          frameStartS;
  logic [3:0]    darkS;
  logic [3:0]    nibbleS;
  logic          litS;
  logic [3:0]    anS;
  logic [6:0]    segS;
  logic          dpS;

  assign frameStartS = (cntR == CNT_ZERO) && (idxR == 2'd0);

  // Dwell counter, digit index, frame-synchronous shadow capture and frame pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cntR    <= CNT_ZERO;
      idxR    <= 2'd0;
      valueR  <= 16'h0000;
      blankR  <= 4'b0000;
      dpMaskR <= 4'b0000;
      lzEnR   <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      if (cntR == CNT_LAST) begin
        cntR <= CNT_ZERO;
        idxR <= idxR + 2'd1;
      end else begin
        cntR <= cntR + {{(CW-1){1'b0}}, 1'b1};
      end
      if (frameStartS) begin
        valueR  <= value_i;
        blankR  <= blank_i;
        dpMaskR <= dp_i;
        lzEnR   <= lz_en_i;
      end
      frame_o <= frameStartS;
    end
  end

  // Per-digit darkness, guard interval and the next pin levels.
  always_comb begin
    darkS[0] = blankR[0];
    darkS[1] = blankR[1] | (lzEnR & (valueR[15:4] == 12'h000));
    darkS[2] = blankR[2] | (lzEnR & (valueR[15:8] == 8'h00));
    darkS[3] = blankR[3] | (lzEnR & (valueR[15:12] == 4'h0));
    case (idxR)
      2'd0:    nibbleS = valueR[3:0];
      2'd1:    nibbleS = valueR[7:4];
      2'd2:    nibbleS = valueR[11:8];
      2'd3:    nibbleS = valueR[15:12];
      default: nibbleS = 4'h0;
    endcase
    // Anodes stay off for the first GUARD_CYCLES of each dwell to avoid ghosting.
    litS = (cntR >= CNT_GUARD) && !darkS[idxR];
    anS  = 4'b1111;
    if (litS) begin
      anS[idxR] = 1'b0;
      segS      = hexSeg(nibbleS);
      dpS       = ~dpMaskR[idxR];
    end else begin
      segS      = 7'b1111111;
      dpS       = 1'b1;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_o  <= 4'b1111;
      seg_o <= 7'b1111111;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= anS;
      seg_o <= segS;
      dp_o  <= dpS;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with an 8-cycle dwell and 2-cycle guard,
// so one frame is 32 clocks.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dpIn;
  logic        lzEn;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  seg7_scan #(.REFRESH_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rstN), .value_i(value), .blank_i(blank), .dp_i(dpIn),
    .lz_en_i(lzEn), .seg_o(seg), .dp_o(dp), .an_o(an), .frame_o(frame)
  );

  always #5 clk = ~clk;

  // Advance to the next negedge at which frame_o is high; bounded.
  task automatic waitFrame(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit found;
    logic expFrame;
    rstN = 1'b0; value = 16'h1A8F; blank = 4'b0000; dpIn = 4'b0000; lzEn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame !== 1'b0)
      $display("FAIL reset_hold: an=%b seg=%b dp=%b frame=%b, required 1111 1111111 1 0",
               an, seg, dp, frame);
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame !== 1'b0) errors++;
    rstN = 1'b1;
    waitFrame(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL first_frame: no frame_o pulse after reset release");
    end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      expFrame = (i == 32) ? 1'b1 : 1'b0;
      checks++;
      if (frame !== expFrame) begin
        errors++;
        $display("FAIL frame_period: cycle %0d frame=%b, required %b", i, frame, expFrame);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0001110) begin
      errors++;
      $display("FAIL pre_reset_lit: an=%b seg=%b, required 1110 0001110", an, seg);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b frame=%b, required 1111 1111111 1 0",
               an, seg, dp, frame);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    waitFrame(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reframe: no frame_o pulse after second reset release");
    end
  endtask

  task automatic test_digits;
    bit found;
    logic [3:0] anTbl[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] segTbl[4] = '{7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001};
    logic [3:0] anE;
    logic [6:0] segE;
    value = 16'h1A8F; blank = 4'b0000; dpIn = 4'b0000; lzEn = 1'b0;
    waitFrame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL digits_frame: no frame_o pulse"); end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        anE  = (c < 2) ? 4'b1111 : anTbl[d];
        segE = (c < 2) ? 7'b1111111 : segTbl[d];
        checks++;
        if (an !== anE || seg !== segE || dp !== 1'b1) begin
          errors++;
          $display("FAIL digits d%0d c%0d: an=%b seg=%b dp=%b, required %b %b 1",
                   d, c, an, seg, dp, anE, segE);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL digits_next_frame: frame=%b, required 1", frame);
    end
  endtask

  task automatic test_no_tearing;
    bit found;
    logic [3:0] anTbl[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] segOld[4] = '{7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001};
    logic [3:0] anE;
    logic [6:0] segE;
    value = 16'h1A8F;
    waitFrame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL tear_frame: no frame_o pulse"); end
    repeat (11) @(negedge clk);
    value = 16'h2222;
    for (int p = 11; p < 32; p++) begin
      anE  = (p % 8 < 2) ? 4'b1111 : anTbl[p / 8];
      segE = (p % 8 < 2) ? 7'b1111111 : segOld[p / 8];
      checks++;
      if (an !== anE || seg !== segE) begin
        errors++;
        $display("FAIL no_tear p%0d: an=%b seg=%b, required %b %b", p, an, seg, anE, segE);
      end
      @(negedge clk);
    end
    checks++;
    if (frame !== 1'b1) begin errors++; $display("FAIL tear_next_frame: frame=%b, required 1", frame); end
    for (int p = 0; p < 32; p++) begin
      anE  = (p % 8 < 2) ? 4'b1111 : anTbl[p / 8];
      segE = (p % 8 < 2) ? 7'b1111111 : 7'b0100100;
      checks++;
      if (an !== anE || seg !== segE) begin
        errors++;
        $display("FAIL new_value p%0d: an=%b seg=%b, required %b %b", p, an, seg, anE, segE);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lz;
    bit found;
    logic [15:0] vals[3] = '{16'h0005, 16'h0000, 16'h0500};
    logic [3:0]  lits[3] = '{4'b0001, 4'b0001, 4'b0111};
    logic [6:0]  segTab[3][4] = '{'{7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111},
                                  '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111},
                                  '{7'b1000000, 7'b1000000, 7'b0010010, 7'b1111111}};
    logic [3:0] anE;
    logic [6:0] segE;
    for (int sc = 0; sc < 3; sc++) begin
      value = vals[sc]; lzEn = 1'b1; blank = 4'b0000; dpIn = 4'b0000;
      waitFrame(found);
      checks++;
      if (!found) begin errors++; $display("FAIL lz_frame sc%0d: no frame_o pulse", sc); end
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 8; c++) begin
          anE  = 4'b1111;
          segE = 7'b1111111;
          if (c >= 2 && lits[sc][d]) begin
            anE[d] = 1'b0;
            segE   = segTab[sc][d];
          end
          checks++;
          if (an !== anE || seg !== segE || dp !== 1'b1) begin
            errors++;
            $display("FAIL lz sc%0d d%0d c%0d: an=%b seg=%b dp=%b, required %b %b 1",
                     sc, d, c, an, seg, dp, anE, segE);
          end
          @(negedge clk);
        end
      end
    end
    lzEn = 1'b0;
  endtask

  task automatic test_blank_dp;
    bit found;
    logic [3:0] anTbl[4]  = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
    logic [6:0] segTbl[4] = '{7'b0011001, 7'b0110000, 7'b1111111, 7'b1111001};
    logic [3:0] anE;
    logic [6:0] segE;
    logic       dpE;
    value = 16'h1234; blank = 4'b0100; dpIn = 4'b0001; lzEn = 1'b0;
    waitFrame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL blank_frame: no frame_o pulse"); end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        anE  = (c < 2) ? 4'b1111 : anTbl[d];
        segE = (c < 2) ? 7'b1111111 : segTbl[d];
        dpE  = (anE == 4'b1110) ? 1'b0 : 1'b1;
        checks++;
        if (an !== anE || seg !== segE || dp !== dpE || an === 4'b1011) begin
          errors++;
          $display("FAIL blank_dp d%0d c%0d: an=%b seg=%b dp=%b, required %b %b %b",
                   d, c, an, seg, dp, anE, segE, dpE);
        end
        @(negedge clk);
      end
    end
    blank = 4'b0000; dpIn = 4'b0000;
  endtask

  task automatic test_scan;
    bit found;
    value = 16'hFFFF; blank = 4'b0000; dpIn = 4'b0000; lzEn = 1'b0;
    waitFrame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL scan_frame: no frame_o pulse"); end
    for (int p = 0; p < 96; p++) begin
      checks++;
      if ($countones(~an) > 1 || (p % 8 < 2 && an !== 4'b1111) ||
          (p % 8 >= 2 && $countones(~an) != 1)) begin
        errors++;
        $display("FAIL scan p%0d: an=%b, required one-hot-low outside guard, 1111 in guard", p, an);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_no_tearing();
    test_lz();
    test_blank_dp();
    test_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
